// File: rtl/polyunit_seq.sv
// Coefficient-wise add/sub/copy/zero sequencer mod Q for the Kyber polynomial unit.
// Streams all N addresses of RAM A/B through a 2-stage read->combine->write pipe into RAM C.

module polyunit_seq_alu #(
    parameter int WIDTH = 12,
    parameter int Q     = 3329
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] res_o
);
    localparam logic [WIDTH:0] QW = (WIDTH+1)'(Q);

    logic [WIDTH:0] a_x, b_x, a_r, b_r, sum;

    // Raw operands are below 2Q, so one conditional subtract fully reduces them.
    always_comb begin
        a_x = {1'b0, a_i};
        b_x = {1'b0, b_i};
        a_r = (a_x >= QW) ? a_x - QW : a_x;
        b_r = (b_x >= QW) ? b_x - QW : b_x;
        sum = a_r + b_r;
        unique case (mode_i)
            2'd0:    res_o = (sum >= QW) ? WIDTH'(sum - QW) : sum[WIDTH-1:0];
            2'd1:    res_o = (a_r >= b_r) ? WIDTH'(a_r - b_r) : WIDTH'(a_r + QW - b_r);
            2'd2:    res_o = a_r[WIDTH-1:0];
            default: res_o = '0;
        endcase
    end
endmodule

module polyunit_seq #(
    parameter int WIDTH = 12,
    parameter int N     = 256,
    parameter int AW    = 8,
    parameter int Q     = 3329
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             rd_en_o,
    output logic [AW-1:0]    rd_addr_o,
    input  logic [WIDTH-1:0] a_data_i,
    input  logic [WIDTH-1:0] b_data_i,
    output logic             wr_en_o,
    output logic [AW-1:0]    wr_addr_o,
    output logic [WIDTH-1:0] wr_data_o
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_t;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wr_req_t;

    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t          state_q;
    logic [1:0]      mode_q;
    logic            busy_q, done_q, rd_en_q;
    logic [AW-1:0]   rd_addr_q;
    // vld_pipe_q[0]: RAM data for s1_addr_q is on a_data/b_data; [1]: write stage live.
    logic [1:0]      vld_pipe_q;
    logic [AW-1:0]   s1_addr_q;
    wr_req_t         wr_q, wr_d;
    logic [WIDTH-1:0] alu_res;

    polyunit_seq_alu #(.WIDTH(WIDTH), .Q(Q)) u_alu (
        .a_i    (a_data_i),
        .b_i    (b_data_i),
        .mode_i (mode_q),
        .res_o  (alu_res)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q    <= mode_i;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                        state_q   <= S_READ;
                    end
                end
                S_READ: begin
                    if (rd_addr_q == LAST) begin
                        rd_en_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + AW'(1);
                    end
                end
                S_DRAIN: begin
                    // The final write is on the bus this cycle; done follows it.
                    if (vld_pipe_q[1] && wr_q.addr == LAST) begin
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_d.addr = s1_addr_q;
        wr_d.data = alu_res;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe_q <= '0;
            s1_addr_q  <= '0;
            wr_q       <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], rd_en_q};
            s1_addr_q  <= rd_addr_q;
            if (vld_pipe_q[0])
                wr_q <= wr_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rd_en_o   = rd_en_q;
    assign rd_addr_o = rd_addr_q;
    assign wr_en_o   = vld_pipe_q[1];
    assign wr_addr_o = wr_q.addr;
    assign wr_data_o = wr_q.data;
endmodule

// File: tb/tb_polyunit_seq.sv
// Self-checking bench for polyunit_seq: constant-fill vector table, handshake and
// reset corner sequences, and random runs against an arithmetic mod-Q reference.

module tb_polyunit_seq;
    localparam int N  = 256;
    localparam int Q  = 3329;
    localparam int W  = 12;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [W-1:0]  a_data = '0, b_data = '0, wr_data;

    logic [W-1:0]  mem_a [N];
    logic [W-1:0]  mem_b [N];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    int wq_addr[$];
    int wq_data[$];
    int wq_cyc[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int done_busy = 0;

    polyunit_seq #(.WIDTH(W), .N(N), .AW(AW), .Q(Q)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .mode_i    (mode),
        .busy_o    (busy),
        .done_o    (done),
        .rd_en_o   (rd_en),
        .rd_addr_o (rd_addr),
        .a_data_i  (a_data),
        .b_data_i  (b_data),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM A/B: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= mem_a[rd_addr];
            b_data <= mem_b[rd_addr];
        end
    end

    // Cycle numbers recorded here are the edge at which the output gets captured.
    always @(negedge clk) begin
        if (wr_en) begin
            wq_addr.push_back(int'(wr_addr));
            wq_data.push_back(int'(wr_data));
            wq_cyc.push_back(cyc + 1);
        end
        if (done) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc + 1;
            done_busy = int'(busy);
        end
    end

    function automatic int golden(input int a, input int b, input int md);
        int ar, br;
        ar = a % Q;
        br = b % Q;
        case (md)
            0:       return (ar + br) % Q;
            1:       return ((ar - br) % Q + Q) % Q;
            2:       return ar;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fill_const(input int a, input int b);
        for (int i = 0; i < N; i++) begin
            mem_a[i] = W'(a);
            mem_b[i] = W'(b);
        end
    endtask

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        done_cnt = 0;
        done_cyc = 0;
        done_busy = 0;
    endtask

    // Entered and left at a negedge. hs=1 fires ignored starts (with toggled mode)
    // at +5 and in the done cycle; the expected data still uses md.
    task automatic run_and_check(input string nm, input logic [1:0] md,
                                 input bit use_const, input int cexp, input bit hs);
        int  c0;
        bit  got_done;
        int  n;
        int  exp;
        clear_mon();
        mode  = md;
        start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        start = 1'b0;
        check({nm, "_busy_rise"}, int'(busy), 1);
        check({nm, "_rd_en_first"}, int'(rd_en), 1);
        check({nm, "_rd_addr_first"}, int'(rd_addr), 0);
        got_done = 1'b0;
        for (int k = 0; k < N + 20 && !got_done; k++) begin
            @(negedge clk);
            start = 1'b0;
            mode  = md;
            if (hs && cyc == c0 + 5) begin
                start = 1'b1;
                mode  = ~md;
            end
            if (done) begin
                got_done = 1'b1;
                if (hs) begin
                    start = 1'b1;
                    mode  = ~md;
                end
            end
        end
        check({nm, "_done_seen"}, int'(got_done), 1);
        @(negedge clk);
        start = 1'b0;
        mode  = md;
        check({nm, "_busy_after_done"}, int'(busy), 0);
        check({nm, "_done_pulses"}, done_cnt, 1);
        check({nm, "_done_latency"}, done_cyc - c0, N + 3);
        check({nm, "_busy_in_done"}, done_busy, 1);
        n = wq_addr.size();
        check({nm, "_write_count"}, n, N);
        if (n > 0) begin
            check({nm, "_first_wr_latency"}, wq_cyc[0] - c0, 3);
            check({nm, "_last_wr_latency"}, wq_cyc[n-1] - c0, N + 2);
        end
        for (int i = 0; i < n && i < N; i++) begin
            exp = use_const ? cexp : golden(int'(mem_a[i]), int'(mem_b[i]), int'(md));
            check($sformatf("%s_addr[%0d]", nm, i), wq_addr[i], i);
            check($sformatf("%s_data[%0d]", nm, i), wq_data[i], exp);
        end
    endtask

    typedef struct {
        string      name;
        int         a;
        int         b;
        logic [1:0] md;
        int         exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit found;

        vecs[0] = '{"add_max_red", 3328, 3328, 2'd0, 3327};
        vecs[1] = '{"add_raw_max", 4095, 4095, 2'd0, 1532};
        vecs[2] = '{"add_small",   5,    7,    2'd0, 12};
        vecs[3] = '{"sub_equal",   1234, 1234, 2'd1, 0};
        vecs[4] = '{"sub_a_is_q",  3329, 0,    2'd1, 0};
        vecs[5] = '{"sub_wrap",    0,    4095, 2'd1, 2563};
        vecs[6] = '{"copy_red",    4095, 17,   2'd2, 766};
        vecs[7] = '{"zero",        100,  200,  2'd3, 0};

        #2;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            fill_const(vecs[v].a, vecs[v].b);
            run_and_check(vecs[v].name, vecs[v].md, 1'b1, vecs[v].exp, 1'b0);
        end

        // Starts at +5 and in the done cycle are ignored; the next run begins one cycle after done.
        fill_const(5, 7);
        run_and_check("hs_ignore", 2'd0, 1'b1, 12, 1'b1);
        fill_const(4095, 1);
        run_and_check("hs_after_done", 2'd2, 1'b1, 766, 1'b0);

        // Asynchronous reset in the middle of the read sweep.
        fill_const(0, 4095);
        mode  = 2'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (rd_addr == AW'(100)) found = 1'b1;
        end
        check("midrst_reach_addr100", int'(found), 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_rd_en", int'(rd_en), 0);
        check("midrst_wr_en", int'(wr_en), 0);
        check("midrst_rd_addr", int'(rd_addr), 0);
        check("midrst_wr_addr", int'(wr_addr), 0);
        check("midrst_wr_data", int'(wr_data), 0);
        clear_mon();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_no_writes", wq_addr.size(), 0);
        check("midrst_idle", int'(busy), 0);
        run_and_check("post_rst", 2'd1, 1'b1, 2563, 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                mem_a[i] = W'($urandom_range(0, 4095));
                mem_b[i] = W'($urandom_range(0, 4095));
            end
            run_and_check($sformatf("rand%0d", r), 2'($urandom_range(0, 3)), 1'b0, 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/polyunit_seq.md
Name: polyunit_seq

Overview:
Initiator-side sequencer for coefficient-wise polynomial add/sub mod q=3329 in the Kyber polynomial unit. On a start pulse it walks all N coefficient addresses of two operand RAMs (A, B), reduces and combines each pair, and writes the result to a destination RAM (C). It asserts done when the last coefficient has been written. It drives the run/done-style handshake seen by the top-level controller and owns the RAM address/enable side of the NTT RAM interface.

Parameters:
WIDTH, 12, coefficient width in bits
N, 256, coefficients per polynomial
AW, 8, address width (log2 N)
Q, 3329, modulus

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request; sampled only in IDLE
mode  in  2  0=ADD (a+b), 1=SUB (a-b), 2=COPY (a), 3=ZERO (writes 0); latched on accepted start
busy  out  1  high from accepted start until done cycle inclusive
done  out  1  one-cycle pulse after the final write
rd_en  out  1  read enable to RAM A and RAM B
rd_addr  out  AW  shared read address for A and B
a_data  in  WIDTH  RAM A read data, valid 1 cycle after rd_en
b_data  in  WIDTH  RAM B read data, valid 1 cycle after rd_en
wr_en  out  1  write enable to RAM C
wr_addr  out  AW  RAM C write address
wr_data  out  WIDTH  RAM C write data, always in [0, Q-1]

Behaviour:
- Reset (async, any time incl. mid-operation): state=IDLE; busy, done, rd_en, wr_en = 0; rd_addr, wr_addr, wr_data = 0; latched mode = 0; pipeline valid bits cleared. No partial writes after rst rises.
- States: IDLE -> READ (start=1) -> DRAIN (after rd_addr N-1 issued) -> FIN (last write done) -> IDLE.
- IDLE: start=1 latches mode, sets busy, goes to READ. start=0 holds.
- READ: rd_en=1 every cycle, rd_addr 0,1,...,N-1 in consecutive cycles; no stalls. After issuing N-1, rd_en=0 next cycle, go to DRAIN.
- Pipeline: cycle t issue rd_addr=i; t+1 a_data/b_data valid, reduce+combine, register; t+2 wr_en=1, wr_addr=i, wr_data=result. Read-to-write latency 2 cycles; throughput 1 coeff/cycle.
- Operand reduction: a' = (a>=Q) ? a-Q : a; same for b'. Inputs 0..4095 (max 4095 < 2Q) are fully reduced by one subtract.
- ADD: s=a'+b' (WIDTH+1 bits); result = (s>=Q) ? s-Q : s.
- SUB: d=a'-b' computed in WIDTH+1-bit signed; result = (d<0) ? d+Q : d.
- COPY: result=a'. ZERO: result=0; reads still issued.
- DRAIN: wait until the write for address N-1 completes, then FIN.
- FIN: done=1 for exactly one cycle, busy still 1; next cycle IDLE, busy=0.
- Timing from start sampled high at edge E0: first rd_en at E0+1 cycle, first wr_en at E0+3, last wr_en at E0+N+2, done at E0+N+3; total N+3 cycles start-to-done.
- start while busy (any non-IDLE state): ignored, no restart, mode unchanged. mode changes mid-run: no effect.
- start in the same cycle done pulses: ignored (state is FIN, not IDLE); a new start is accepted one cycle later.
- wr_en is never asserted except for addresses 0..N-1 of the current run; each address is written exactly once per run, in ascending order.

Test Plan:
- Reset: assert rst mid-READ at rd_addr=100 -> all outputs 0 immediately (async); no further wr_en; a new start then runs from addr 0.
- SUB wrap: a=0, b=4095 all addresses, mode=1 -> every wr_data=2563 (b'=766, 0-766+3329); done at start+259 cycles.
- ADD overflow: a=3328, b=3328 -> wr_data=3327; a=4095, b=4095 -> 1532; a=5, b=7 -> 12.
- SUB equal/zero: a=b=1234 -> 0; a=3329, b=0 -> 0 (a reduced to 0).
- Handshake: pulse start again at cycles +5 and at done cycle, with mode toggled -> ignored, exactly 256 writes with original mode; start one cycle after done -> accepted.
- Random: 3 runs of random a,b in [0,4095], random mode -> wr_data matches the golden model ((a%Q) op (b%Q)) mod Q, wr_addr ascending 0..255, single done pulse per run.
